// File: rtl/aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_mode_ctrl
// Purpose  : ECB / CBC / CTR block-chaining controller around a single-block
//            AES-128 core. It owns IV/counter chaining, the input/output XOR
//            and a small output FIFO, so upstream sees a plain valid/ready
//            block stream. The key never passes through this block.
// Revision : 1.0 - initial release
// ============================================================================
module aes_mode_ctrl #(
  parameter int BLK_W      = 128,
  parameter int CNT_W      = 32,
  parameter int OBUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_dec,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             core_start,
  output logic             core_dec,
  output logic [BLK_W-1:0] core_din,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_dout,
  output logic             busy
);

  localparam int              c_aw       = $clog2(OBUF_DEPTH);
  localparam logic [c_aw:0]   c_depth    = (c_aw+1)'(OBUF_DEPTH);
  localparam logic [c_aw:0]   c_cnt_one  = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
  localparam logic [1:0]      c_mode_cbc = 2'd1;
  localparam logic [1:0]      c_mode_ctr = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_IN   = 2'd1,
    S_CORE_REQ  = 2'd2,
    S_CORE_WAIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic             r_dec;
  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] r_pdata;
  logic             r_plast;
  logic             r_core_start;
  logic             r_core_dec;
  logic [BLK_W-1:0] r_core_din;

  logic [BLK_W-1:0] r_mem      [OBUF_DEPTH];
  logic             r_mem_last [OBUF_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic             w_is_cbc;
  logic             w_is_ctr;
  logic             w_in_fire;
  logic             w_push;
  logic             w_pop;
  logic [BLK_W-1:0] w_din_next;
  logic             w_dec_next;
  logic [BLK_W-1:0] w_result;
  logic [BLK_W-1:0] w_chain_next;
  logic [BLK_W-1:0] w_ctr_next;

  // Reserved mode 3 falls through to ECB because neither decode matches it.
  assign w_is_cbc  = (r_mode == c_mode_cbc);
  assign w_is_ctr  = (r_mode == c_mode_ctr);

  // Admission requires FIFO space, which guarantees the in-flight block a slot.
  assign in_ready  = (r_state == S_WAIT_IN) && (r_count < c_depth);
  assign w_in_fire = in_valid && in_ready;
  assign w_push    = (r_state == S_CORE_WAIT) && core_done;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  assign out_data   = r_mem[r_rd_ptr];
  assign out_last   = r_mem_last[r_rd_ptr];
  assign core_start = r_core_start;
  assign core_dec   = r_core_dec;
  assign core_din   = r_core_din;
  assign busy       = (r_state != S_IDLE);

  // Counter increment touches only the low CNT_W bits; the nonce part is kept.
  generate
    if (CNT_W >= BLK_W) begin : g_ctr_full
      assign w_ctr_next = r_chain + BLK_W'(1);
    end else begin : g_ctr_part
      assign w_ctr_next = {r_chain[BLK_W-1:CNT_W], r_chain[CNT_W-1:0] + CNT_W'(1)};
    end
  endgenerate

  // Core request contents, computed from the block being accepted.
  always_comb begin
    w_din_next = in_data;
    w_dec_next = r_dec;
    if (w_is_ctr) begin
      w_din_next = r_chain;
      w_dec_next = 1'b0;
    end else if (w_is_cbc && !r_dec) begin
      w_din_next = in_data ^ r_chain;
    end
  end

  // Result and next chain value, applied on the core_done cycle.
  always_comb begin
    w_result     = core_dout;
    w_chain_next = r_chain;
    if (w_is_ctr) begin
      w_result     = core_dout ^ r_pdata;
      w_chain_next = w_ctr_next;
    end else if (w_is_cbc) begin
      if (r_dec) begin
        w_result     = core_dout ^ r_chain;
        w_chain_next = r_pdata;
      end else begin
        w_chain_next = core_dout;
      end
    end
  end

  // Message FSM with registered core request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'd0;
      r_dec        <= 1'b0;
      r_chain      <= '0;
      r_pdata      <= '0;
      r_plast      <= 1'b0;
      r_core_start <= 1'b0;
      r_core_dec   <= 1'b0;
      r_core_din   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_mode  <= cfg_mode;
            r_dec   <= cfg_dec;
            r_chain <= cfg_iv;
            r_state <= S_WAIT_IN;
          end
        end
        S_WAIT_IN: begin
          if (w_in_fire) begin
            r_pdata      <= in_data;
            r_plast      <= in_last;
            r_core_din   <= w_din_next;
            r_core_dec   <= w_dec_next;
            r_core_start <= 1'b1;
            r_state      <= S_CORE_REQ;
          end
        end
        S_CORE_REQ: begin
          r_core_start <= 1'b0;
          r_state      <= S_CORE_WAIT;
        end
        S_CORE_WAIT: begin
          if (core_done) begin
            r_chain <= w_chain_next;
            r_state <= r_plast ? S_IDLE : S_WAIT_IN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO; contents survive across messages until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem[i]      <= '0;
        r_mem_last[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]      <= w_result;
        r_mem_last[r_wr_ptr] <= r_plast;
        r_wr_ptr             <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mode_ctrl
// Purpose  : Directed self-checking bench for aes_mode_ctrl with a
//            behavioural AES-128 core (key 000102..0f, fixed latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mode_ctrl;

  localparam int c_depth = 2;

  logic         clk;
  logic         rst_n;
  logic         cfg_start;
  logic [1:0]   cfg_mode;
  logic         cfg_dec;
  logic [127:0] cfg_iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_start;
  logic         core_dec;
  logic [127:0] core_din;
  logic         core_done;
  logic [127:0] core_dout;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  aes_mode_ctrl #(.BLK_W(128), .CNT_W(32), .OBUF_DEPTH(c_depth)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_dec(cfg_dec), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_dec(core_dec), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural AES-128 ----------------
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk  [11];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic init_tables();
    logic [127:0] key;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   v;
    logic [7:0]   inv;
    for (int x = 0; x < 256; x++) begin
      v   = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(v, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      isb[sb[x]] = v;
    end
    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] x;
    x = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[x[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
      x = x ^ rk[r];
    end
    return x;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] x;
    x = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      for (int k = 0; k < 16; k++) s[k] = x[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*((c+rr)%4)] = s[rr+4*c];
      for (int k = 0; k < 16; k++) x[127-8*k -: 8] = isb[t[k]];
      x = x ^ rk[r];
      if (r != 0) begin
        for (int k = 0; k < 16; k++) t[k] = x[127-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
          t[4*c+1] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
          t[4*c+2] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
          t[4*c+3] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
        end
        for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
      end
    end
    return x;
  endfunction

  // Behavioural core: result appears with core_done four cycles after the request.
  logic [2:0]   m_cnt;
  logic [127:0] m_din;
  logic         m_dec;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= 3'd0;
      m_din     <= '0;
      m_dec     <= 1'b0;
      core_done <= 1'b0;
      core_dout <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        m_din <= core_din;
        m_dec <= core_dec;
        m_cnt <= 3'd3;
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1) begin
          core_done <= 1'b1;
          core_dout <= m_dec ? aes_dec(m_din) : aes_enc(m_din);
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [1:0] mode, input logic dec, input logic [127:0] iv);
    cfg_mode  = mode;
    cfg_dec   = dec;
    cfg_iv    = iv;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
  endtask

  // Offers a block, waits for acceptance, then checks the core request.
  task automatic send_block(input string tag, input logic [127:0] d, input logic last,
                            input logic [127:0] exp_din, input logic exp_dec);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    check1({tag, "_accept_timeout"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check1({tag, "_core_start"}, core_start, 1'b1);
    check({tag, "_core_din"}, core_din, exp_din);
    check1({tag, "_core_dec"}, core_dec, exp_dec);
    tick();
    check1({tag, "_core_start_pulse"}, core_start, 1'b0);
  endtask

  // Waits for a result, checks it, and pops it.
  task automatic pop_check(input string tag, input logic [127:0] exp_d, input logic exp_l,
                           output logic saw_done);
    int n;
    n = 0;
    saw_done = 1'b0;
    while (!out_valid && n < 60) begin
      saw_done = core_done;
      tick();
      n++;
    end
    check1({tag, "_out_timeout"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check1({tag, "_last"}, out_last, exp_l);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [127:0] pt, iv_a, iv_b, iv_ctr, iv_ctr2, p0, p1, e0, e1;
  logic [127:0] c [3];
  logic [127:0] b [4];
  logic         sd;

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = 2'd0; cfg_dec = 1'b0; cfg_iv = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    init_tables();
    pt      = 128'h00112233445566778899aabbccddeeff;
    iv_ctr  = {96'ha5a5a5a5a5a5a5a5a5a5a5a5, 32'hffffffff};
    iv_ctr2 = {96'ha5a5a5a5a5a5a5a5a5a5a5a5, 32'h00000000};
    repeat (2) tick();

    // Reset state
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_core_start", core_start, 1'b0);
    check1("rst_core_dec", core_dec, 1'b0);
    check("rst_core_din", core_din, '0);
    check("rst_out_data", out_data, '0);
    check1("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
    tick();

    // ECB encrypt, FIPS-197 vector
    start_msg(2'd0, 1'b0, '0);
    send_block("ecb", pt, 1'b1, pt, 1'b0);
    pop_check("ecb", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, sd);
    check1("ecb_done_to_valid_latency", sd, 1'b1);
    check1("ecb_busy_dropped", busy, 1'b0);

    // CBC encrypt, IV=0, 3 identical blocks
    start_msg(2'd1, 1'b0, '0);
    c[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    c[1] = aes_enc(pt ^ c[0]);
    c[2] = aes_enc(pt ^ c[1]);
    send_block("cbce0", pt, 1'b0, pt, 1'b0);
    pop_check("cbce0", c[0], 1'b0, sd);
    send_block("cbce1", pt, 1'b0, pt ^ c[0], 1'b0);
    pop_check("cbce1", c[1], 1'b0, sd);
    send_block("cbce2", pt, 1'b1, pt ^ c[1], 1'b0);
    pop_check("cbce2", c[2], 1'b1, sd);

    // CBC decrypt of the same ciphertexts
    start_msg(2'd1, 1'b1, '0);
    send_block("cbcd0", c[0], 1'b0, c[0], 1'b1);
    pop_check("cbcd0", pt, 1'b0, sd);
    send_block("cbcd1", c[1], 1'b0, c[1], 1'b1);
    pop_check("cbcd1", pt, 1'b0, sd);
    send_block("cbcd2", c[2], 1'b1, c[2], 1'b1);
    pop_check("cbcd2", pt, 1'b1, sd);

    // CTR with counter wrap in the low 32 bits
    p0 = 128'h0123456789abcdeffedcba9876543210;
    p1 = 128'hdeadbeef00000000cafef00d12345678;
    e0 = p0 ^ aes_enc(iv_ctr);
    e1 = p1 ^ aes_enc(iv_ctr2);
    start_msg(2'd2, 1'b0, iv_ctr);
    send_block("ctre0", p0, 1'b0, iv_ctr, 1'b0);
    pop_check("ctre0", e0, 1'b0, sd);
    send_block("ctre1", p1, 1'b1, iv_ctr2, 1'b0);
    pop_check("ctre1", e1, 1'b1, sd);
    start_msg(2'd2, 1'b1, iv_ctr);
    send_block("ctrd0", e0, 1'b0, iv_ctr, 1'b0);
    pop_check("ctrd0", p0, 1'b0, sd);
    send_block("ctrd1", e1, 1'b1, iv_ctr2, 1'b0);
    pop_check("ctrd1", p1, 1'b1, sd);

    // Backpressure: FIFO of 2, out_ready held low, 4 blocks
    for (int i = 0; i < 4; i++) b[i] = {4{32'h11111111 * (i + 1)}};
    start_msg(2'd0, 1'b0, '0);
    send_block("bp0", b[0], 1'b0, b[0], 1'b0);
    send_block("bp1", b[1], 1'b0, b[1], 1'b0);
    in_valid = 1'b1;
    in_data  = b[2];
    for (int i = 0; i < 10; i++) begin
      check1("bp_in_ready_held", in_ready, 1'b0);
      tick();
    end
    check1("bp_full_out_valid", out_valid, 1'b1);
    pop_check("bp_out0", aes_enc(b[0]), 1'b0, sd);
    send_block("bp2", b[2], 1'b0, b[2], 1'b0);
    pop_check("bp_out1", aes_enc(b[1]), 1'b0, sd);
    send_block("bp3", b[3], 1'b1, b[3], 1'b0);
    pop_check("bp_out2", aes_enc(b[2]), 1'b0, sd);
    pop_check("bp_out3", aes_enc(b[3]), 1'b1, sd);
    check1("bp_drained", out_valid, 1'b0);

    // Asynchronous reset during CORE_WAIT of block 2
    start_msg(2'd0, 1'b0, '0);
    send_block("rs0", b[0], 1'b0, b[0], 1'b0);
    send_block("rs1", b[1], 1'b0, b[1], 1'b0);
    check1("rs_pre_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rs_out_valid", out_valid, 1'b0);
    check1("rs_in_ready", in_ready, 1'b0);
    check1("rs_busy", busy, 1'b0);
    check1("rs_core_start", core_start, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_msg(2'd0, 1'b0, '0);
    send_block("rs_new", b[3], 1'b1, b[3], 1'b0);
    pop_check("rs_new", aes_enc(b[3]), 1'b1, sd);
    tick();
    check1("rs_no_stale", out_valid, 1'b0);

    // cfg_start ignored during WAIT_IN; chaining continues from original IV
    iv_a = 128'h000102030405060708090a0b0c0d0e0f;
    iv_b = 128'hffeeddccbbaa99887766554433221100;
    c[0] = aes_enc(b[0] ^ iv_a);
    c[1] = aes_enc(b[1] ^ c[0]);
    start_msg(2'd1, 1'b0, iv_a);
    send_block("ign0", b[0], 1'b0, b[0] ^ iv_a, 1'b0);
    pop_check("ign0", c[0], 1'b0, sd);
    cfg_mode = 2'd0; cfg_dec = 1'b1; cfg_iv = iv_b; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check1("ign_still_busy", busy, 1'b1);
    send_block("ign1", b[1], 1'b1, b[1] ^ c[0], 1'b0);
    pop_check("ign1", c[1], 1'b1, sd);

    // Reserved mode behaves as ECB
    start_msg(2'd3, 1'b0, iv_b);
    send_block("m3", pt, 1'b1, pt, 1'b0);
    pop_check("m3", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, sd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Block-chaining controller that wraps the single-block AES-128 core and adds ECB, CBC and CTR modes for encrypt and decrypt over multi-block messages.
- Sits between the streaming data path and the AES core.
- Owns IV/counter chaining, input/output XOR and an output buffer, so upstream sees a plain valid/ready block stream.
- Key handling and expansion stay in the core; this block never sees the key.

Parameters:
BLK_W, 128, block width; only 128 is supported, and it must match the core.
CNT_W, 32, CTR counter width, taken from the low bits of the IV; 1..BLK_W.
OBUF_DEPTH, 4, output FIFO depth in blocks; power of 2, at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: latch cfg_*, start a message
cfg_mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved (treated as ECB)
cfg_dec  in  1  1=decrypt (ignored in CTR)
cfg_iv  in  BLK_W  CBC IV or CTR initial counter block
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid&in_ready
in_data  in  BLK_W  input block
in_last  in  1  last block of the message
out_valid  out  1  output FIFO non-empty
out_ready  in  1  downstream accepts
out_data  out  BLK_W  result block
out_last  out  1  last result of the message
core_start  out  1  one-cycle request to the core
core_dec  out  1  core direction
core_din  out  BLK_W  core input block
core_done  in  1  one-cycle completion pulse from the core
core_dout  in  BLK_W  core result, valid with core_done
busy  out  1  state != IDLE

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, FIFO empty, chain and counter registers 0.
- FSM states: IDLE, WAIT_IN, CORE_REQ, CORE_WAIT.
- IDLE:
  - in_ready=0.
  - cfg_start latches mode, dec and iv into the chain register, then goes to WAIT_IN.
  - cfg_start in any other state is ignored.
- WAIT_IN:
  - in_ready = (fifo_count < OBUF_DEPTH).
  - On handshake: register in_data and in_last, go to CORE_REQ.
- CORE_REQ:
  - Drive core_start=1 for exactly one cycle with core_din/core_dec from the mode rules, then go to CORE_WAIT.
  - core_din and core_dec stay stable until core_done.
- CORE_WAIT:
  - On core_done: compute the result, push it into the FIFO with its last flag, update the chain register.
  - Next state is IDLE if last, else WAIT_IN.
  - core_done in any other state is ignored.
- Mode rules (P = registered input, C = chain register):
  - ECB: core_din=P, core_dec=cfg_dec, result=core_dout.
  - CBC encrypt: core_din=P^C, result=core_dout, C<=core_dout.
  - CBC decrypt: core_din=P, result=core_dout^C, C<=P.
  - CTR: core_din=C, core_dec=0, result=core_dout^P.
    - Then C[CNT_W-1:0] increments modulo 2^CNT_W; C[BLK_W-1:CNT_W] is unchanged.
- Latency: input handshake at cycle T, core_start at T+1, FIFO push on the core_done cycle D, out_valid at D+1 when the FIFO was empty.
- Only one block is in flight at a time. in_ready is never high in CORE_REQ or CORE_WAIT.
- FIFO:
  - out_data/out_last show the head entry; pop on out_valid&out_ready.
  - Push and pop in the same cycle are both allowed, and fifo_count is unchanged.
  - FIFO full blocks in_ready only. A block already in flight can always be pushed, because admission required space.
- FIFO contents persist across messages. A new cfg_start may be accepted while old results are still draining.
- Asynchronous reset mid-operation clears the FSM, FIFO, chain and outputs immediately.
  - The core must be reset together with this block. No pending core_done is honoured after reset.

Test Plan:
- ECB encrypt with a behavioural core using key 000102..0f: pt 00112233445566778899aabbccddeeff, in_last=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1; core_start at T+1; busy drops after the push.
- CBC encrypt with IV=0, 3 blocks, each equal to the FIPS pt -> block0 equals the ECB result. Then CBC decrypt with IV=0 on those 3 ciphertexts -> all three plaintexts recovered, out_last only on the third.
- CTR with cfg_iv low 32 bits = ffffffff and upper bits = a5..a5, 2 blocks -> 2nd core_din has low 32 bits = 00000000 and upper bits still a5..a5. Decrypting with the same IV restores the input; core_dec=0 throughout.
- Backpressure with OBUF_DEPTH=2, out_ready=0, 4-block message -> exactly 2 blocks accepted, in_ready held 0. Raising out_ready drains the FIFO in order, and all 4 results match the model.
- Reset mid-message: assert rst_n=0 during CORE_WAIT of block 2 -> out_valid, in_ready, busy and core_start become 0 immediately. After release, a new ECB message runs correctly with no stale output.
- cfg_start pulsed during WAIT_IN with a different IV -> ignored, and chaining continues from the original IV. cfg_mode=3 -> output identical to ECB.
